// File: rtl/fp12_pkg.sv
// Shared FP12 definitions: field widths, constants, adder latency
// and the reduction sequencer state encoding.
package fp12_pkg;

    localparam int FP12_SIGN_W = 1;
    localparam int FP12_EXP_W  = 5;
    localparam int FP12_MAN_W  = 6;
    localparam int FP12_W      = FP12_SIGN_W + FP12_EXP_W + FP12_MAN_W;

    localparam logic [FP12_W-1:0] FP12_ZERO = 12'h000;

    localparam int ADD12_LAT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } red_state_t;

endpackage

// File: rtl/add_tag_pipe.sv
// Valid-bit delay line mirroring the shared adder pipeline.
// Ports: clk, rst (sync, active-high), tag_in, tag_out, count (popcount).
module add_tag_pipe #(
    parameter int DEPTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tag_in,
    output logic             tag_out,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe <= {pipe[DEPTH-2:0], tag_in};
        end
    end

    assign tag_out = pipe[DEPTH-1];

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(pipe[i]);
        end
    end

endmodule

// File: rtl/add_reduce_ctrl_12.sv
// Reduces a stream of FP12 elements to one sum through a shared
// pipelined adder, keeping several partial sums in flight.
// Ports: clk_i, rst_i, start_i, len_i, skip_neg_en_i, data_i,
//   data_valid_i, data_ready_o, busy_o, sum_o, sum_valid_o,
//   add_data_1_o, add_data_2_o, add_en_o, add_sum_i.
module add_reduce_ctrl_12
    import fp12_pkg::*;
#(
    parameter int ADD_LAT = ADD12_LAT,
    parameter int LEN_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              skip_neg_en_i,
    input  logic [FP12_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              busy_o,
    output logic [FP12_W-1:0] sum_o,
    output logic              sum_valid_o,
    output logic [FP12_W-1:0] add_data_1_o,
    output logic [FP12_W-1:0] add_data_2_o,
    output logic              add_en_o,
    input  logic [FP12_W-1:0] add_sum_i
);

    localparam int CNT_W = $clog2(ADD_LAT + 2);

    red_state_t        state;
    logic [LEN_W-1:0]  rem;
    logic              skip_neg;
    logic              hold_v;
    logic [FP12_W-1:0] hold_d;
    logic [FP12_W-1:0] final_d;

    logic              p_valid;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  live;
    logic              accept;
    logic              issue;
    logic              hold_load;
    logic              hold_clr;
    logic              fin;
    logic [FP12_W-1:0] fin_d;

    // Tag pipe is cleared on reset so partials still inside the
    // adder are never seen as live after an abort.
    add_tag_pipe #(
        .DEPTH (ADD_LAT),
        .CNT_W (CNT_W)
    ) u_tags (
        .clk     (clk_i),
        .rst     (rst_i),
        .tag_in  (issue),
        .tag_out (p_valid),
        .count   (inflight)
    );

    assign live         = inflight + CNT_W'(hold_v);
    assign accept       = (state == ST_ACCUM) && data_valid_i;
    assign data_ready_o = (state == ST_ACCUM);
    assign busy_o       = (state != ST_IDLE);

    always_comb begin
        issue        = 1'b0;
        add_en_o     = 1'b0;
        add_data_1_o = FP12_ZERO;
        add_data_2_o = FP12_ZERO;
        hold_load    = 1'b0;
        hold_clr     = 1'b0;
        fin          = 1'b0;
        fin_d        = FP12_ZERO;
        unique case (state)
            ST_ACCUM: begin
                if (accept && p_valid) begin
                    issue        = 1'b1;
                    add_en_o     = 1'b1;
                    add_data_1_o = add_sum_i;
                    add_data_2_o = data_i;
                end else if (accept && hold_v) begin
                    issue        = 1'b1;
                    add_en_o     = 1'b1;
                    add_data_1_o = hold_d;
                    add_data_2_o = data_i;
                    hold_clr     = 1'b1;
                end else if (accept) begin
                    // Lone element rides the adder as a pass-through
                    // so it becomes a tagged partial like any other.
                    issue        = 1'b1;
                    add_data_1_o = data_i;
                end else if (p_valid && hold_v) begin
                    issue        = 1'b1;
                    add_en_o     = 1'b1;
                    add_data_1_o = add_sum_i;
                    add_data_2_o = hold_d;
                    hold_clr     = 1'b1;
                end else if (p_valid) begin
                    hold_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (p_valid && hold_v) begin
                    issue        = 1'b1;
                    add_en_o     = 1'b1;
                    add_data_1_o = add_sum_i;
                    add_data_2_o = hold_d;
                    hold_clr     = 1'b1;
                end else if (p_valid && live == CNT_W'(1)) begin
                    fin   = 1'b1;
                    fin_d = add_sum_i;
                end else if (p_valid) begin
                    hold_load = 1'b1;
                end else if (hold_v && inflight == '0) begin
                    fin   = 1'b1;
                    fin_d = hold_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rem         <= '0;
            skip_neg    <= 1'b0;
            hold_v      <= 1'b0;
            hold_d      <= FP12_ZERO;
            final_d     <= FP12_ZERO;
            sum_o       <= FP12_ZERO;
            sum_valid_o <= 1'b0;
        end else begin
            sum_valid_o <= 1'b0;
            if (hold_load) begin
                assert (!hold_v);
                hold_v <= 1'b1;
                hold_d <= add_sum_i;
            end else if (hold_clr) begin
                hold_v <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        skip_neg <= skip_neg_en_i;
                        if (len_i == '0) begin
                            final_d <= FP12_ZERO;
                            state   <= ST_DONE;
                        end else begin
                            rem   <= len_i;
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        rem <= rem - 1'b1;
                        if (rem == LEN_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fin) begin
                        final_d <= fin_d;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    sum_o       <= (skip_neg && final_d[FP12_W-1])
                                   ? FP12_ZERO : final_d;
                    sum_valid_o <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
